rc4_decrypt_loop: RTL
=====================

# rc4_decrypt_loop

RC4 keystream/decrypt stage ("loop 3") of the key-search datapath. After S-array initialisation and key scheduling, it runs the RC4 PRGA over the 256×8 S memory. It XORs each keystream byte with the encrypted-message ROM and writes the plaintext byte to the decrypted-message RAM. Each byte is presented to the downstream character checker through a new_char/compared_char handshake, and the run aborts on the checker's start_over.

## Interface
- MSG_LEN, 32: message length in bytes; k counts 0..MSG_LEN.
- clok  in  1  system clock, all logic on rising edge.
- resetm  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled in IDLE; begins a decrypt run (key schedule done).
- start_over  in  1  from checker; abort run, return to IDLE.
- compared_char  in  1  from checker; one-cycle ack that the current byte passed.
- s_addr  out  8  S memory address.
- s_wrdata  out  8  S memory write data.
- s_wren  out  1  S memory write enable.
- s_rddata  in  8  S memory read data, valid one cycle after s_addr registered.
- rom_addr  out  5  encrypted ROM address.
- rom_rddata  in  8  encrypted byte, one-cycle read latency.
- dec_addr  out  5  decrypted RAM address.
- dec_wrdata  out  8  decrypted RAM write data.
- dec_wren  out  1  decrypted RAM write enable.
- char_out  out  8  current decrypted byte (to checker char_recieved).
- new_char  out  1  one-cycle pulse: char_out valid.
- k  out  6  current byte index (to checker char_count).
- done  out  1  level: all MSG_LEN bytes produced and acked.

## Operation
- Internal registers: i, j, si, sj (8 bit).
- Arithmetic: i+1, j+si, and si+sj are all mod 256 (8-bit wrap).
- Reset: state IDLE. All outputs and i, j, si, sj, k are 0.
- All outputs are registered.
- The states below list the actions performed on the clock edge taken in each state:
  - IDLE: clears i, j, k, done. If start is high, goes to SET_I.
  - SET_I: i<=i+1; s_addr<=i+1; s_wren<=0. Goes to WAIT_SI.
  - WAIT_SI: no action. Goes to GET_SI.
  - GET_SI: si<=s_rddata; j<=j+s_rddata; s_addr<=j+s_rddata. Goes to WAIT_SJ.
  - WAIT_SJ: no action. Goes to GET_SJ.
  - GET_SJ: sj<=s_rddata; s_addr<=i; s_wrdata<=s_rddata; s_wren<=1. Goes to WR_SJ.
  - WR_SJ: s_addr<=j; s_wrdata<=si; s_wren<=1. Goes to SET_F.
  - SET_F: s_wren<=0; s_addr<=si+sj; rom_addr<=k. Goes to WAIT_F.
  - WAIT_F: no action. Goes to GET_F.
  - GET_F: char_out and dec_wrdata <= s_rddata^rom_rddata; dec_addr<=k; dec_wren<=1; new_char<=1. Goes to WAIT_ACK.
  - WAIT_ACK: dec_wren<=0; new_char<=0. Stays until compared_char=1, then goes to NEXT.
  - NEXT: k<=k+1. If k==MSG_LEN-1, goes to DONE, else goes to SET_I.
  - DONE: done=1, k=MSG_LEN. Holds until start_over or reset.
- start_over has the highest priority:
  - From any state, the next edge gives state IDLE with s_wren, dec_wren and new_char at 0, and i=j=k=0. char_out keeps its last value.
  - start_over beats a simultaneous compared_char or start.
- i==j: both writes hit the same address, so S is unchanged; no special case.
- new_char is never high for more than one cycle per byte.
- At most one new_char pulse is issued per k value until compared_char is received.

## Timing
- Latency from start: start sampled at edge 0; new_char is high for the cycle after edge 9.
- Latency from ack: compared_char sampled at edge a; the next new_char is high after edge a+10.
- A byte with no stall takes 11 cycles.
- The S write for i occurs on the cycle after GET_SJ; the write for j occurs the cycle after that.
- F is read one cycle after the second write, so read-after-write ordering is preserved.
- k is stable from SET_I through WAIT_ACK.
- k becomes MSG_LEN (32) the edge after the final ack, so the checker sees char_count≥32.

## Test plan
- Reset: assert resetm mid-run (WR_SJ) -> all outputs 0 immediately; state IDLE; no further writes.
- Identity S (S[x]=x), enc ROM all 0x00, start=1, ack each byte:
  - byte 0: i=1, j=1, char_out=0x02, dec_addr=0;
  - byte 1: i=2, j=3, S[2]=3, S[3]=2, char_out=0x05.
- Ack stall: hold compared_char=0 for 20 cycles in WAIT_ACK -> exactly one new_char pulse, k stays 0, no S or dec writes.
- Abort: pulse start_over during WAIT_SJ -> next cycle s_wren=0, i=j=k=0; restart with start -> first byte again at k=0.
- Full run: 32 bytes all acked -> 32 new_char pulses, 32 dec writes at addresses 0..31, then k=32, done=1, no further pulses.
- Collision: compared_char and start_over high together in WAIT_ACK -> IDLE, k=0, done=0.

Source files
------------

// File: rtl/rc4_decrypt_loop.sv
// rtl/rc4_decrypt_loop.sv - RC4 PRGA keystream XOR decrypt stage with checker handshake
module rc4_decrypt_loop #(
    parameter int MSG_LEN = 32
) (
    input  logic       clok,
    input  logic       resetm,
    input  logic       start,
    input  logic       start_over,
    input  logic       compared_char,
    output logic [7:0] s_addr,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    input  logic [7:0] s_rddata,
    output logic [4:0] rom_addr,
    input  logic [7:0] rom_rddata,
    output logic [4:0] dec_addr,
    output logic [7:0] dec_wrdata,
    output logic       dec_wren,
    output logic [7:0] char_out,
    output logic       new_char,
    output logic [5:0] k,
    output logic       done
);

    localparam logic [5:0] LAST_K = 6'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_SET_I, ST_WAIT_SI, ST_GET_SI, ST_WAIT_SJ, ST_GET_SJ, ST_WR_SJ,
        ST_SET_F, ST_WAIT_F, ST_GET_F, ST_WAIT_ACK, ST_NEXT, ST_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [5:0] k_q, k_d;
    logic [7:0] s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d;
    logic       s_wren_q, s_wren_d;
    logic [4:0] rom_addr_q, rom_addr_d, dec_addr_q, dec_addr_d;
    logic [7:0] dec_wrdata_q, dec_wrdata_d, char_out_q, char_out_d;
    logic       dec_wren_q, dec_wren_d, new_char_q, new_char_d, done_q, done_d;
    logic [7:0] j_sum, f_addr, i_inc, plain;

    // 8-bit wrapping arithmetic shared by the datapath
    assign j_sum  = j_q + s_rddata;
    assign f_addr = si_q + sj_q;
    assign i_inc  = i_q + 8'd1;
    assign plain  = s_rddata ^ rom_rddata;

    // State register
    always_ff @(posedge clok or posedge resetm) begin
        if (resetm) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start_over overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_SET_I;
            ST_SET_I:    state_d = ST_WAIT_SI;
            ST_WAIT_SI:  state_d = ST_GET_SI;
            ST_GET_SI:   state_d = ST_WAIT_SJ;
            ST_WAIT_SJ:  state_d = ST_GET_SJ;
            ST_GET_SJ:   state_d = ST_WR_SJ;
            ST_WR_SJ:    state_d = ST_SET_F;
            ST_SET_F:    state_d = ST_WAIT_F;
            ST_WAIT_F:   state_d = ST_GET_F;
            ST_GET_F:    state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: if (compared_char) state_d = ST_NEXT;
            ST_NEXT:     state_d = (k_q == LAST_K) ? ST_DONE : ST_SET_I;
            ST_DONE:     state_d = ST_DONE;
            default:     state_d = ST_IDLE;
        endcase
        if (start_over) state_d = ST_IDLE;
    end

    // Per-state datapath and output updates; everything holds unless a state changes it
    always_comb begin
        i_d          = i_q;
        j_d          = j_q;
        si_d         = si_q;
        sj_d         = sj_q;
        k_d          = k_q;
        s_addr_d     = s_addr_q;
        s_wrdata_d   = s_wrdata_q;
        s_wren_d     = s_wren_q;
        rom_addr_d   = rom_addr_q;
        dec_addr_d   = dec_addr_q;
        dec_wrdata_d = dec_wrdata_q;
        dec_wren_d   = dec_wren_q;
        char_out_d   = char_out_q;
        new_char_d   = new_char_q;
        done_d       = done_q;
        case (state_q)
            ST_IDLE: begin
                i_d    = 8'd0;
                j_d    = 8'd0;
                k_d    = 6'd0;
                done_d = 1'b0;
            end
            ST_SET_I: begin
                i_d      = i_inc;
                s_addr_d = i_inc;
                s_wren_d = 1'b0;
            end
            ST_GET_SI: begin
                si_d     = s_rddata;
                j_d      = j_sum;
                s_addr_d = j_sum;
            end
            ST_GET_SJ: begin
                sj_d       = s_rddata;
                s_addr_d   = i_q;
                s_wrdata_d = s_rddata;
                s_wren_d   = 1'b1;
            end
            ST_WR_SJ: begin
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
                s_wren_d   = 1'b1;
            end
            ST_SET_F: begin
                s_wren_d   = 1'b0;
                s_addr_d   = f_addr;
                rom_addr_d = k_q[4:0];
            end
            ST_GET_F: begin
                char_out_d   = plain;
                dec_wrdata_d = plain;
                dec_addr_d   = k_q[4:0];
                dec_wren_d   = 1'b1;
                new_char_d   = 1'b1;
            end
            ST_WAIT_ACK: begin
                dec_wren_d = 1'b0;
                new_char_d = 1'b0;
            end
            ST_NEXT: begin
                k_d = k_q + 6'd1;
                if (k_q == LAST_K) done_d = 1'b1;
            end
            default: ;
        endcase
        if (start_over) begin
            i_d        = 8'd0;
            j_d        = 8'd0;
            k_d        = 6'd0;
            s_wren_d   = 1'b0;
            dec_wren_d = 1'b0;
            new_char_d = 1'b0;
            done_d     = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clok or posedge resetm) begin
        if (resetm) begin
            i_q          <= 8'd0;
            j_q          <= 8'd0;
            si_q         <= 8'd0;
            sj_q         <= 8'd0;
            k_q          <= 6'd0;
            s_addr_q     <= 8'd0;
            s_wrdata_q   <= 8'd0;
            s_wren_q     <= 1'b0;
            rom_addr_q   <= 5'd0;
            dec_addr_q   <= 5'd0;
            dec_wrdata_q <= 8'd0;
            dec_wren_q   <= 1'b0;
            char_out_q   <= 8'd0;
            new_char_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            i_q          <= i_d;
            j_q          <= j_d;
            si_q         <= si_d;
            sj_q         <= sj_d;
            k_q          <= k_d;
            s_addr_q     <= s_addr_d;
            s_wrdata_q   <= s_wrdata_d;
            s_wren_q     <= s_wren_d;
            rom_addr_q   <= rom_addr_d;
            dec_addr_q   <= dec_addr_d;
            dec_wrdata_q <= dec_wrdata_d;
            dec_wren_q   <= dec_wren_d;
            char_out_q   <= char_out_d;
            new_char_q   <= new_char_d;
            done_q       <= done_d;
        end
    end

    assign s_addr     = s_addr_q;
    assign s_wrdata   = s_wrdata_q;
    assign s_wren     = s_wren_q;
    assign rom_addr   = rom_addr_q;
    assign dec_addr   = dec_addr_q;
    assign dec_wrdata = dec_wrdata_q;
    assign dec_wren   = dec_wren_q;
    assign char_out   = char_out_q;
    assign new_char   = new_char_q;
    assign k          = k_q;
    assign done       = done_q;

endmodule
